// File: rtl/uart_pkg.sv
// Definitions shared by the UART receiver and transmitter.
// Covers the frame size, the line levels and the receive state encoding.
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int INDEX_BITS = $clog2(DATA_BITS);

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_state_t;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer that brings an asynchronous level into the CLK domain.
// The reset value is a parameter so that an idle line does not look like a start bit.
module uart_sync #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic CLK,
  input  logic RESET,
  input  logic line,
  output logic synced
);

  logic meta;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      meta   <= RESET_VALUE;
      synced <= RESET_VALUE;
    end else begin
      meta   <= line;
      synced <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, one stop bit, mid-bit sampling at CLKS_PER_BIT clocks per bit.
// It hands bytes over with valid/ready and flags framing and overrun errors.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter bit MSB_FIRST    = 1'b0
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 rx,
  input  logic                 data_ready,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 framing_error,
  output logic                 overrun_error,
  output logic                 busy
);

  localparam logic [7:0]            BIT_END    = 8'(CLKS_PER_BIT);
  localparam logic [7:0]            HALF_BIT   = 8'(CLKS_PER_BIT / 2);
  localparam logic [INDEX_BITS-1:0] LAST_INDEX = INDEX_BITS'(DATA_BITS - 1);

  logic                  rx_s;
  uart_state_t           state, state_next;
  logic [7:0]            cnt, cnt_next;
  logic [INDEX_BITS-1:0] index, index_next;
  logic [INDEX_BITS-1:0] bit_pos;
  logic [DATA_BITS-1:0]  shift, shift_next;
  logic                  stop_sample;
  logic                  frame_good;
  logic                  frame_bad;

  uart_sync #(
    .RESET_VALUE(STOP_BIT)
  ) sync_rx (
    .CLK   (CLK),
    .RESET (RESET),
    .line  (rx),
    .synced(rx_s)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      cnt   <= '0;
      index <= '0;
      shift <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      index <= index_next;
      shift <= shift_next;
    end
  end

  // The first bit on the wire lands in bit 0 or bit 7 depending on bit order.
  assign bit_pos = MSB_FIRST ? (LAST_INDEX - index) : index;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    index_next = index;
    shift_next = shift;
    case (state)
      IDLE: begin
        if (rx_s == START_BIT) begin
          state_next = START;
          cnt_next   = 8'd1;
        end
      end
      START: begin
        if (cnt == HALF_BIT) begin
          if (rx_s == START_BIT) begin
            state_next = DATA;
            cnt_next   = 8'd1;
            index_next = '0;
          end else begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      DATA: begin
        if (cnt == BIT_END) begin
          shift_next[bit_pos] = rx_s;
          cnt_next            = 8'd1;
          index_next          = index + 1'b1;
          if (index == LAST_INDEX) begin
            state_next = STOP;
          end
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      STOP: begin
        if (cnt == BIT_END) begin
          cnt_next   = '0;
          state_next = (rx_s == STOP_BIT) ? IDLE : BREAK;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      BREAK: begin
        if (rx_s == STOP_BIT) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        index_next = '0;
      end
    endcase
  end

  always_comb begin
    busy        = (state != IDLE);
    stop_sample = (state == STOP) && (cnt == BIT_END);
    frame_good  = stop_sample && (rx_s == STOP_BIT);
    frame_bad   = stop_sample && (rx_s != STOP_BIT);
  end

  // A finished byte is dropped rather than stalling the receiver when the consumer lags.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      data          <= '0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      framing_error <= frame_bad;
      overrun_error <= frame_good && data_valid && !data_ready;
      if (frame_good && (!data_valid || data_ready)) begin
        data       <= shift;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: two instances (16 clocks/bit LSB first, 2 clocks/bit MSB first)
// checked every cycle against a timestamp-based frame model, plus directed scenarios.
module tb_uart_rx;

  int   cpb [2] = '{16, 2};
  bit   msb [2] = '{1'b0, 1'b1};

  logic       CLK   = 1'b0;
  logic       RESET = 1'b1;
  logic       rx [2];
  logic       data_ready [2];
  logic [7:0] data [2];
  logic       data_valid [2];
  logic       framing_error [2];
  logic       overrun_error [2];
  logic       busy [2];

  int checks = 0;
  int errors = 0;

  // Model: per-instance synchronizer copy, phase (0 idle, 1 in frame, 2 line stuck low)
  bit         s1 [2];
  bit         s2 [2];
  int         phase [2];
  int         t0 [2];
  int         cyc = 0;
  logic [7:0] bits [2];
  logic [7:0] exp_data [2];
  bit         exp_dv [2];
  bit         exp_fe [2];
  bit         exp_ov [2];

  int         ready_mode [2];
  int         dv_cycles [2];
  int         fe_count [2];
  int         ov_count [2];
  logic [7:0] acc_q0 [$];
  logic [7:0] acc_q1 [$];

  uart_rx #(.CLKS_PER_BIT(16), .MSB_FIRST(1'b0)) dut0 (
    .CLK          (CLK),
    .RESET        (RESET),
    .rx           (rx[0]),
    .data_ready   (data_ready[0]),
    .data         (data[0]),
    .data_valid   (data_valid[0]),
    .framing_error(framing_error[0]),
    .overrun_error(overrun_error[0]),
    .busy         (busy[0])
  );

  uart_rx #(.CLKS_PER_BIT(2), .MSB_FIRST(1'b1)) dut1 (
    .CLK          (CLK),
    .RESET        (RESET),
    .rx           (rx[1]),
    .data_ready   (data_ready[1]),
    .data         (data[1]),
    .data_valid   (data_valid[1]),
    .framing_error(framing_error[1]),
    .overrun_error(overrun_error[1]),
    .busy         (busy[1])
  );

  always #5 CLK = ~CLK;

  task automatic check_output(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      s1[i]       = 1'b1;
      s2[i]       = 1'b1;
      phase[i]    = 0;
      t0[i]       = 0;
      bits[i]     = 8'h00;
      exp_data[i] = 8'h00;
      exp_dv[i]   = 1'b0;
      exp_fe[i]   = 1'b0;
      exp_ov[i]   = 1'b0;
    end
  endtask

  // Predicts the effect of the coming rising edge from cycle offsets since the start edge.
  task automatic model_step(int i);
    bit rs;
    bit good;
    int rel;
    int half;
    int k;
    rs    = s2[i];
    s2[i] = s1[i];
    s1[i] = rx[i];
    half  = cpb[i] / 2;
    good  = 1'b0;
    exp_fe[i] = 1'b0;
    exp_ov[i] = 1'b0;
    case (phase[i])
      0: begin
        if (!rs) begin
          phase[i] = 1;
          t0[i]    = cyc;
        end
      end
      1: begin
        rel = cyc - t0[i];
        if (rel == half) begin
          if (rs) phase[i] = 0;
        end else if (rel > half && ((rel - half) % cpb[i]) == 0) begin
          k = (rel - half) / cpb[i];
          if (k <= 8) bits[i][msb[i] ? (8 - k) : (k - 1)] = rs;
          else if (rs) begin
            good     = 1'b1;
            phase[i] = 0;
          end else begin
            exp_fe[i] = 1'b1;
            phase[i]  = 2;
          end
        end
      end
      default: begin
        if (rs) phase[i] = 0;
      end
    endcase
    if (good) begin
      if (!exp_dv[i] || data_ready[i]) begin
        exp_data[i] = bits[i];
        exp_dv[i]   = 1'b1;
      end else begin
        exp_ov[i] = 1'b1;
      end
    end else if (exp_dv[i] && data_ready[i]) begin
      exp_dv[i] = 1'b0;
    end
  endtask

  // Compare on the falling edge, then advance the model with the inputs the next edge will see.
  initial begin
    model_reset();
    forever begin
      @(negedge CLK);
      if (RESET) model_reset();
      for (int i = 0; i < 2; i++) begin
        check_output($sformatf("dut%0d busy_valid_ferr_oerr_data", i),
                     {20'd0, busy[i], data_valid[i], framing_error[i], overrun_error[i], data[i]},
                     {20'd0, phase[i] != 0, exp_dv[i], exp_fe[i], exp_ov[i], exp_data[i]});
      end
      if (!RESET) begin
        for (int i = 0; i < 2; i++) begin
          if (data_valid[i]) dv_cycles[i]++;
          if (framing_error[i]) fe_count[i]++;
          if (overrun_error[i]) ov_count[i]++;
          if (data_valid[i] && data_ready[i]) begin
            if (i == 0) acc_q0.push_back(data[0]);
            else acc_q1.push_back(data[1]);
          end
        end
        for (int i = 0; i < 2; i++) model_step(i);
        cyc++;
      end
    end
  end

  initial begin
    data_ready[0] = 1'b0;
    data_ready[1] = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (ready_mode[i] == 2) data_ready[i] = 1'($urandom_range(0, 1));
        else data_ready[i] = (ready_mode[i] == 1);
      end
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  task automatic hold_line(int i, bit v, int n);
    rx[i] = v;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic apply_stimulus(int i, logic [7:0] b, bit stop_v);
    hold_line(i, 1'b0, cpb[i]);
    for (int j = 0; j < 8; j++) hold_line(i, msb[i] ? b[7 - j] : b[j], cpb[i]);
    hold_line(i, stop_v, cpb[i]);
  endtask

  task automatic random_traffic(int i, int frames);
    int kind;
    for (int f = 0; f < frames; f++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        hold_line(i, 1'b0, $urandom_range(1, cpb[i]));
      end else if (kind == 1) begin
        apply_stimulus(i, 8'($urandom), 1'b0);
        hold_line(i, 1'b0, $urandom_range(0, 3 * cpb[i]));
      end else begin
        apply_stimulus(i, 8'($urandom), 1'b1);
      end
      hold_line(i, 1'b1, $urandom_range(0, 2 * cpb[i]));
    end
  endtask

  initial begin
    int d, f, o, n;
    rx[0] = 1'b1;
    rx[1] = 1'b1;
    ready_mode[0] = 0;
    ready_mode[1] = 0;
    idle(3);
    RESET = 1'b0;
    idle(2);

    for (int i = 0; i < 2; i++)
      check_output($sformatf("reset_state%0d", i),
                   {20'd0, busy[i], data_valid[i], framing_error[i], overrun_error[i], data[i]}, 32'd0);

    // Single byte with the consumer always ready
    ready_mode[0] = 1;
    idle(2);
    d = dv_cycles[0]; f = fe_count[0]; n = acc_q0.size();
    apply_stimulus(0, 8'hA5, 1'b1);
    hold_line(0, 1'b1, 32);
    check_output("a5_valid_cycles", 32'(dv_cycles[0] - d), 32'd1);
    check_output("a5_ferr", 32'(fe_count[0] - f), 32'd0);
    check_output("a5_count", 32'(acc_q0.size() - n), 32'd1);
    check_output("a5_byte", 32'(acc_q0[n]), 32'hA5);
    check_output("a5_model", 32'(exp_data[0]), 32'hA5);

    // False start: short low pulse
    d = dv_cycles[0]; f = fe_count[0];
    hold_line(0, 1'b0, 5);
    check_output("false_start_busy_high", 32'(busy[0]), 32'd1);
    hold_line(0, 1'b1, 30);
    check_output("false_start_busy_low", 32'(busy[0]), 32'd0);
    check_output("false_start_valid", 32'(dv_cycles[0] - d), 32'd0);
    check_output("false_start_ferr", 32'(fe_count[0] - f), 32'd0);

    // Bad stop bit followed by a long break
    d = dv_cycles[0]; f = fe_count[0];
    apply_stimulus(0, 8'h3C, 1'b0);
    hold_line(0, 1'b0, 100);
    check_output("break_ferr_count", 32'(fe_count[0] - f), 32'd1);
    check_output("break_valid", 32'(dv_cycles[0] - d), 32'd0);
    check_output("break_busy", 32'(busy[0]), 32'd1);
    hold_line(0, 1'b1, 5);
    check_output("break_release_busy", 32'(busy[0]), 32'd0);

    // Overrun: consumer stalled across two frames
    ready_mode[0] = 0;
    idle(2);
    o = ov_count[0];
    apply_stimulus(0, 8'h11, 1'b1);
    hold_line(0, 1'b1, 32);
    apply_stimulus(0, 8'h22, 1'b1);
    hold_line(0, 1'b1, 32);
    check_output("overrun_data", 32'(data[0]), 32'h11);
    check_output("overrun_valid", 32'(data_valid[0]), 32'd1);
    check_output("overrun_pulses", 32'(ov_count[0] - o), 32'd1);
    check_output("overrun_model", 32'(exp_data[0]), 32'h11);
    ready_mode[0] = 1;
    idle(3);
    check_output("overrun_drain_valid", 32'(data_valid[0]), 32'd0);
    check_output("overrun_drain_byte", 32'(acc_q0[acc_q0.size() - 1]), 32'h11);

    // Reset in the middle of bit 4, then a clean frame
    n = acc_q0.size();
    hold_line(0, 1'b0, 16);
    hold_line(0, 1'b1, 4 * 16 + 8);
    RESET = 1'b1;
    hold_line(0, 1'b1, 2);
    check_output("midreset_outputs",
                 {20'd0, busy[0], data_valid[0], framing_error[0], overrun_error[0], data[0]}, 32'd0);
    RESET = 1'b0;
    hold_line(0, 1'b1, 72);
    apply_stimulus(0, 8'h5A, 1'b1);
    hold_line(0, 1'b1, 32);
    check_output("midreset_count", 32'(acc_q0.size() - n), 32'd1);
    check_output("midreset_byte", 32'(acc_q0[acc_q0.size() - 1]), 32'h5A);

    // Back-to-back frames at 2 clocks per bit, MSB first
    ready_mode[1] = 1;
    idle(2);
    n = acc_q1.size(); f = fe_count[1]; o = ov_count[1];
    apply_stimulus(1, 8'h81, 1'b1);
    apply_stimulus(1, 8'h7E, 1'b1);
    hold_line(1, 1'b1, 10);
    check_output("b2b_count", 32'(acc_q1.size() - n), 32'd2);
    check_output("b2b_first", 32'(acc_q1[n]), 32'h81);
    check_output("b2b_second", 32'(acc_q1[n + 1]), 32'h7E);
    check_output("b2b_errors", 32'((fe_count[1] - f) + (ov_count[1] - o)), 32'd0);

    // Random traffic on both receivers with a random consumer
    ready_mode[0] = 2;
    ready_mode[1] = 2;
    n = acc_q0.size() + acc_q1.size();
    fork
      random_traffic(0, 25);
      random_traffic(1, 60);
    join
    ready_mode[0] = 1;
    ready_mode[1] = 1;
    idle(40);
    check_output("random_delivered", 32'((acc_q0.size() + acc_q1.size()) > n), 32'd1);
    check_output("random_idle", {30'd0, busy[0], busy[1]}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clocks per serial bit; legal range 2..255.
REQ-002 SHALL have parameter MSB_FIRST, default 0: 0 = data bit 0 received first, 1 = data bit 7 received first.
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port RESET  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port rx  input  1  serial line; idle high, asynchronous to CLK.
REQ-006 SHALL have port data_ready  input  1  consumer accepts data this cycle when data_valid=1.
REQ-007 SHALL have port data  output  8  received byte, held stable while data_valid=1.
REQ-008 SHALL have port data_valid  output  1  byte available; held until accepted.
REQ-009 SHALL have port framing_error  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 SHALL have port overrun_error  output  1  one-cycle pulse: frame completed while data_valid=1 and data_ready=0.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer (rx_s); the synchronizer resets to 1.
REQ-013 Frame SHALL be: start bit 0, 8 data bits, stop bit 1.
REQ-014 SHALL implement states IDLE, START, DATA, STOP, BREAK; bit-clock counter cnt; bit index 0..7.
REQ-015 IDLE: rx_s=0 -> START with cnt=1.
REQ-016 START: cnt increments each cycle; at cnt=CLKS_PER_BIT/2 (floor), rx_s=1 -> IDLE (false start, no outputs); rx_s=0 -> DATA with cnt=1, index=0.
REQ-017 DATA: at cnt=CLKS_PER_BIT sample rx_s into shift register at position given by MSB_FIRST, cnt=1, index+1; after 8th sample -> STOP with cnt=1.
REQ-018 STOP: at cnt=CLKS_PER_BIT sample rx_s; 1 -> frame good, IDLE; 0 -> framing_error pulse next cycle, byte discarded, -> BREAK.
REQ-019 BREAK: remain until rx_s=1, then IDLE; a low line held indefinitely SHALL produce exactly one framing_error.
REQ-020 Good frame: next cycle data is loaded and data_valid=1 if output register is empty, or data_ready=1 in the same cycle as the load.
REQ-021 Good frame while data_valid=1 and data_ready=0: old data retained, new byte dropped, overrun_error pulses one cycle.
REQ-022 data_valid SHALL clear the cycle after data_valid=1 and data_ready=1 with no simultaneous load.
REQ-023 Receive state machine SHALL not stall on data_valid; a new frame may start the cycle after a good stop sample.
REQ-024 Counter width SHALL be 8 bits; cnt never exceeds CLKS_PER_BIT.

Reset
REQ-025 RESET=1 SHALL force immediately: state=IDLE, cnt=0, index=0, shift register=0, data=0x00, data_valid=0, framing_error=0, overrun_error=0, busy=0, synchronizer=1.
REQ-026 RESET mid-frame SHALL abandon the frame with no output; after release, reception restarts at the next rx_s=0 in IDLE.

Structure
REQ-027 Shared package uart_pkg SHALL hold the state enumeration, DATA_BITS=8, and START/STOP bit level constants, shared with the transmitter.
REQ-028 The 2-flop synchronizer SHALL be a sub-module named uart_sync (parameterised reset value); the remainder is in uart_rx.

Verification
REQ-029 CLKS_PER_BIT=16, MSB_FIRST=0, byte 0xA5 sent LSB first, data_ready=1 -> data=0xA5, data_valid high exactly 1 cycle, framing_error=0.
REQ-030 rx low for 5 cycles then high, CLKS_PER_BIT=16 -> false start: busy returns to 0, no data_valid, no framing_error.
REQ-031 Byte 0x3C with stop bit forced 0, then rx held low 100 cycles -> exactly one framing_error, data_valid stays 0, busy=1 until rx returns high.
REQ-032 data_ready=0, frames 0x11 then 0x22 -> data=0x11 held, overrun_error one pulse on second frame; then data_ready=1 -> data_valid clears.
REQ-033 Assert RESET during bit 4 of frame 0xFF, release, send 0x5A -> only 0x5A delivered, all outputs 0 during reset.
REQ-034 CLKS_PER_BIT=2, MSB_FIRST=1, back-to-back frames 0x81, 0x7E with no idle gap -> both delivered in order, no errors.
